// File: rtl/column_scroll_matrix.sv
// Left-scrolling COLS-wide window of 8-bit glyph columns, double-buffered onto a
// row-multiplexed LED matrix. Define COLUMN_SCROLL_MATRIX_BRIGHTNESS_EN to add a brightness input.

module column_scroll_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       copy_en,
    input  logic [7:0] next_col,
    input  logic [2:0] row,
    output logic [7:0] shadow_col,
    output logic       pix
);
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] display_q, display_d;

    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        if (clear) begin
            shadow_d = '0;
        end else if (shift_en) begin
            shadow_d = next_col;
        end
        // Snapshot takes the registered shadow; same-cycle shifts land next frame.
        if (copy_en) begin
            display_d = shadow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            display_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
        end
    end

    assign shadow_col = shadow_q;
    assign pix        = display_q[row];
endmodule

module column_scroll_matrix #(
    parameter int COLS    = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         col_in,
    input  logic               col_valid,
    input  logic               clear,
`ifdef COLUMN_SCROLL_MATRIX_BRIGHTNESS_EN
    input  logic [DWELL_W-1:0] brightness,
`endif
    output logic [7:0]         row_sel,
    output logic [COLS-1:0]    col_out,
    output logic               frame_start
);
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    typedef struct packed {
        logic [2:0]         row;
        logic [DWELL_W-1:0] dwell;
    } scan_t;

    scan_t                 scan_q, scan_d;
    logic                  copy_en;
    logic                  drive_en;
    logic [COLS-1:0][7:0]  shadow_col;
    logic [COLS-1:0]       pix;
    logic [7:0]            row_sel_q, row_sel_d;
    logic [COLS-1:0]       col_out_q, col_out_d;
    logic                  frame_start_q, frame_start_d;

    always_comb begin
        scan_d       = scan_q;
        scan_d.dwell = scan_q.dwell + DWELL_W'(1);
        copy_en      = 1'b0;
        if (scan_q.dwell == DWELL_MAX) begin
            scan_d.row = scan_q.row + 3'd1;
            copy_en    = (scan_q.row == 3'd7);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_lane
            logic [7:0] next_col;
            if (gi == COLS - 1) begin : g_tail
                assign next_col = col_in;
            end else begin : g_body
                assign next_col = shadow_col[gi+1];
            end
            column_scroll_lane u_lane (
                .clk        (clk),
                .rst        (rst),
                .clear      (clear),
                .shift_en   (col_valid),
                .copy_en    (copy_en),
                .next_col   (next_col),
                .row        (scan_q.row),
                .shadow_col (shadow_col[gi]),
                .pix        (pix[gi])
            );
        end
    endgenerate

    // dwell==0 is always blank so the row switch never ghosts into the next row.
    always_comb begin
`ifdef COLUMN_SCROLL_MATRIX_BRIGHTNESS_EN
        drive_en = (scan_q.dwell != '0) && (scan_q.dwell <= brightness);
`else
        drive_en = (scan_q.dwell != '0);
`endif
        row_sel_d     = drive_en ? (8'd1 << scan_q.row) : 8'd0;
        col_out_d     = drive_en ? pix : '0;
        frame_start_d = (scan_q.row == 3'd0) && (scan_q.dwell == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q        <= '0;
            row_sel_q     <= '0;
            col_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            scan_q        <= scan_d;
            row_sel_q     <= row_sel_d;
            col_out_q     <= col_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign col_out     = col_out_q;
    assign frame_start = frame_start_q;
endmodule
